imem_loader: RTL

- Write-side counterpart to the instruction fetch path. Fetch only reads instruction memory; this block fills it.
- Accepts a byte stream from a host link (UART/debug bridge) over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and issues one-cycle word writes to the IM write port.
- Holds the CPU (gates PC_Write/IR_Write upstream) until a complete program is loaded.

---
 rtl/imem_loader_if.sv | 9 +
 rtl/imem_loader.sv | 113 +++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte-stream valid/ready handshake into the instruction-memory loader
interface imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  modport master (output in_data, in_valid, in_last, input in_ready);
  modport slave (input in_data, in_valid, in_last, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit IM word writes and holds the CPU until loaded
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  imem_loader_if.slave      s,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, ERR} state_t;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                fire;
  logic                word_end;
  logic                can_start;
  logic [ADDR_W:0]     count_inc;
  assign fire      = (state_q == COLLECT) && s.in_valid;
  assign word_end  = fire && ((byte_idx_q == 2'd3) || s.in_last);
  assign can_start = start && (state_q inside {IDLE, DONE, ERR});
  assign count_inc = word_count_q + 1'b1;
  // state and datapath registers; reset cancels any load in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      word_count_q <= '0;
      last_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      word_count_q <= word_count_d;
      last_q       <= last_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end
  // next state: a WRITE always lasts one cycle, then finishes, overflows or keeps collecting
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: state_d = can_start ? COLLECT : state_q;
      COLLECT:         state_d = word_end ? WRITE : COLLECT;
      WRITE:           state_d = last_q ? DONE : (count_inc == FULL) ? ERR : COLLECT;
      default:         state_d = IDLE;
    endcase
  end
  // datapath: lane the byte into the word, snapshot the finished word so the write port holds it
  always_comb begin
    addr_d       = addr_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    word_count_d = word_count_q;
    last_d       = last_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if (can_start) begin
      addr_d       = '0;
      byte_idx_d   = '0;
      word_d       = '0;
      word_count_d = '0;
      last_d       = 1'b0;
    end
    if (fire) begin
      word_d[{byte_idx_q, 3'b000} +: 8] = s.in_data;
      byte_idx_d = byte_idx_q + 2'd1;
      last_d     = s.in_last;
    end
    if (word_end) begin
      mem_addr_d  = addr_q;
      mem_wdata_d = word_d;
    end
    if (state_q == WRITE) begin
      addr_d       = addr_q + 1'b1;
      word_count_d = count_inc;
      byte_idx_d   = '0;
      word_d       = '0;
    end
  end
  // outputs decoded from state only; the hold stays up in ERR so a partial program never runs
  always_comb begin
    s.in_ready = state_q == COLLECT;
    mem_we     = state_q == WRITE;
    busy       = state_q inside {COLLECT, WRITE};
    done       = state_q == DONE;
    err        = state_q == ERR;
    cpu_hold   = state_q inside {COLLECT, WRITE, ERR};
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    word_count = word_count_q;
  end
endmodule
